// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register chain.
package pipe_pkg;

  // Width needed to hold an occupancy value in 0..depth.
  function automatic int unsigned cnt_w_f(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam logic PIPE_RST_DATA = '0;

endpackage

// File: rtl/pipe_stage.sv
// One valid+data slot of the chain; loads from upstream when the chain accepts into it.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             acc,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } pipe_item_t;

  pipe_item_t item_q;
  pipe_item_t item_d;

  // Flush drops the valid bit only; payload registers keep their contents.
  always_comb begin
    item_d = item_q;
    if (clr) begin
      item_d.valid = 1'b0;
    end else if (acc) begin
      item_d.valid = up_valid;
      if (up_valid) begin
        item_d.data = up_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      item_q <= '{valid: 1'b0, data: {WIDTH{PIPE_RST_DATA}}};
    end else begin
      item_q <= item_d;
    end
  end

  assign valid = item_q.valid;
  assign data  = item_q.data;

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic pipeline register: DEPTH stages with valid/ready handshake, bubble collapsing and flush.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = cnt_w_f(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  logic             act_c;
  logic [DEPTH-1:0] valid_c;
  logic [DEPTH-1:0] acc_c;
  logic [DEPTH-1:0] pop_c;
  logic [DEPTH-1:0] up_valid_c;
  logic [WIDTH-1:0] data_c    [DEPTH];
  logic [WIDTH-1:0] up_data_c [DEPTH];
  logic             push_c;
  logic             drain_c;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign act_c = en & ~flush;

  // Ready ripples from the output back to the input within the same cycle.
  always_comb begin
    acc_c = '0;
    pop_c = '0;
    pop_c[DEPTH-1] = act_c & valid_c[DEPTH-1] & out_ready;
    acc_c[DEPTH-1] = act_c & (~valid_c[DEPTH-1] | pop_c[DEPTH-1]);
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      pop_c[i] = valid_c[i] & acc_c[i+1];
      acc_c[i] = act_c & (~valid_c[i] | pop_c[i]);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign up_valid_c[g] = in_valid;
      assign up_data_c[g]  = in_data;
    end else begin : g_body
      assign up_valid_c[g] = valid_c[g-1];
      assign up_data_c[g]  = data_c[g-1];
    end

    pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .clr     (flush),
      .acc     (acc_c[g]),
      .up_valid(up_valid_c[g]),
      .up_data (up_data_c[g]),
      .valid   (valid_c[g]),
      .data    (data_c[g])
    );
  end

  // Occupancy moves only on an input accept or an output pop.
  assign push_c  = in_valid & acc_c[0];
  assign drain_c = pop_c[DEPTH-1];

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push_c && !drain_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_c && drain_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign in_ready  = acc_c[0];
  assign out_valid = valid_c[DEPTH-1] & act_c;
  assign out_data  = data_c[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Randomised and directed checks of pipe_reg_chain against a slot-position model of the chain.
module tb_pipe_reg_chain;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: each held item has a slot position 0..DEPTH-1, oldest first.
  int               pos_q[$];
  logic [WIDTH-1:0] dat_q[$];
  int               m_ahead;

  logic exp_act, exp_ov, exp_ir;
  logic got;

  pipe_reg_chain #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // An item may step forward unless the slot ahead is still occupied after this cycle;
  // the output acts as an extra slot that is free only when out_ready is high.
  function automatic logic calc_in_ready(input logic actv, input logic orr);
    int ahead;
    if (!actv) return 1'b0;
    ahead = orr ? int'(DEPTH) + 1 : int'(DEPTH);
    foreach (pos_q[k]) ahead = (pos_q[k] + 1 < ahead) ? pos_q[k] + 1 : pos_q[k];
    return (ahead > 0);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      pos_q.delete();
      dat_q.delete();
    end else if (en) begin
      m_ahead = out_ready ? int'(DEPTH) + 1 : int'(DEPTH);
      foreach (pos_q[k]) begin
        if (pos_q[k] + 1 < m_ahead) pos_q[k] = pos_q[k] + 1;
        m_ahead = pos_q[k];
      end
      if (pos_q.size() > 0 && pos_q[0] == int'(DEPTH)) begin
        void'(pos_q.pop_front());
        void'(dat_q.pop_front());
      end
      if (in_valid && m_ahead > 0) begin
        pos_q.push_back(0);
        dat_q.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_act = en && !flush;
      exp_ov  = exp_act && pos_q.size() > 0 && pos_q[0] == int'(DEPTH) - 1;
      exp_ir  = calc_in_ready(exp_act, out_ready);
      chk("in_ready", 32'(in_ready), 32'(exp_ir));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("count", 32'(count), 32'(pos_q.size()));
      if (exp_ov) chk("out_data", out_data, dat_q[0]);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    en        = 1'b1;
    flush     = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    out_ready = 1'b1;
    cycle();

    // Streaming: first item visible DEPTH-1 edges after its accepting edge.
    in_valid = 1'b1; in_data = 32'h11; cycle();
    in_data = 32'h22; cycle();
    in_data = 32'h33; cycle();
    in_valid = 1'b0;
    chk("stream_v0", 32'(out_valid), 32'd1);
    chk("stream_d0", out_data, 32'h11);
    cycle();
    chk("stream_d1", out_data, 32'h22);
    cycle();
    chk("stream_d2", out_data, 32'h33);
    idle(3);

    // Back-pressure fill: only three of five offered items fit.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(k);
      cycle();
    end
    chk("bp_count", 32'(count), 32'd3);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_pop_ready", 32'(in_ready), 32'd1);
    chk("bp_d0", out_data, 32'hA0);
    cycle();
    chk("bp_d1", out_data, 32'hA1);
    cycle();
    chk("bp_d2", out_data, 32'hA2);
    idle(3);

    // Bubble collapse under stall.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h5; cycle();
    in_valid = 1'b0; cycle();
    in_valid = 1'b1; in_data = 32'h6; cycle();
    in_valid = 1'b0;
    chk("bubble_count", 32'(count), 32'd2);
    chk("bubble_valid", 32'(out_valid), 32'd1);
    chk("bubble_data", out_data, 32'h5);

    // Flush while full, with an item offered in the flush cycle.
    in_valid = 1'b1; in_data = 32'hB0; cycle();
    in_valid = 1'b0; cycle();
    chk("flush_full", 32'(count), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h77;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    idle(4);

    // Enable freeze.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hC1; cycle();
    in_data = 32'hC2; cycle();
    in_valid = 1'b0;
    en = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("freeze_count", 32'(count), 32'd2);
      chk("freeze_out_valid", 32'(out_valid), 32'd0);
    end
    en = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      cycle();
      got = out_valid;
    end
    chk("freeze_resume_valid", 32'(got), 32'd1);
    chk("freeze_first", out_data, 32'hC1);
    cycle();
    chk("freeze_second", out_data, 32'hC2);
    idle(3);

    // Asynchronous reset with two items held.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hD1; cycle();
    in_data = 32'hD2; cycle();
    in_valid = 1'b0;
    cycle();
    chk("arst_pre_count", 32'(count), 32'd2);
    #1 rst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    cycle();

    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      en        = ($urandom_range(0, 7) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      cycle();
    end
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
